// File: rtl/sample_sequencer.sv
// Time-multiplexed owner of the shared sample bus: periodically sweeps the enabled
// channels, strobes each one, captures its sample and pushes {channel, sample} downstream.
module sample_sequencer #(
    parameter logic [18:0] BASE_ADDR    = 19'h00F0,
    parameter int          NUM_CHANNELS = 16,
    parameter int          DATA_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_bus_en,
    input  logic        cmd_bus_wr,
    input  logic [18:0] cmd_bus_addr,
    input  logic [31:0] cmd_bus_data,
    output logic [7:0]  channel_select,
    output logic        output_sample,
    input  logic [31:0] sample_data,
    output logic [23:0] fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic        busy,
    output logic        overflow,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_PUSH    = 3'd4
    } state_e;

    localparam int          WAIT_CYCLES = (DATA_LATENCY > 1) ? (DATA_LATENCY - 2) : 0;
    localparam logic [3:0]  WAIT_LOAD   = WAIT_CYCLES[3:0];

    function automatic logic [7:0] lowest_set(input logic [NUM_CHANNELS-1:0] v);
        logic [7:0] idx;
        idx = 8'd0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 8'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [NUM_CHANNELS-1:0] clear_bit(input logic [NUM_CHANNELS-1:0] v,
                                                          input logic [7:0] idx);
        logic [NUM_CHANNELS-1:0] r;
        r = v;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (idx == 8'(i)) begin
                r[i] = 1'b0;
            end else begin
                r[i] = v[i];
            end
        end
        return r;
    endfunction

    state_e                  state_q, state_d;
    logic [NUM_CHANNELS-1:0] mask_q, mask_d;
    logic [NUM_CHANNELS-1:0] sweep_q, sweep_d;
    logic [31:0]             period_q, period_d;
    logic [31:0]             cnt_q, cnt_d;
    logic                    run_q, run_d;
    logic                    ovf_q, ovf_d;
    logic                    ovr_q, ovr_d;
    logic [7:0]              ch_q, ch_d;
    logic [3:0]              wait_q, wait_d;
    logic [15:0]             sample_q, sample_d;

    logic                    wr_s, wr_mask_s, wr_period_s, wr_ctrl_s, clr_s, tick_s;
    logic [NUM_CHANNELS-1:0] mask_wdata_s;
    logic [15:0]             unused_sample_s;

    assign wr_s        = cmd_bus_en & cmd_bus_wr;
    assign wr_mask_s   = wr_s & (cmd_bus_addr == BASE_ADDR);
    assign wr_period_s = wr_s & (cmd_bus_addr == (BASE_ADDR + 19'd1));
    assign wr_ctrl_s   = wr_s & (cmd_bus_addr == (BASE_ADDR + 19'd2));
    assign clr_s       = wr_ctrl_s & cmd_bus_data[1];
    assign tick_s      = run_q & (period_q != 32'd0) & (cnt_q == (period_q - 32'd1));
    assign unused_sample_s = sample_data[31:16];

    // Mask write data: channels beyond the 32-bit data word read as zero.
    always_comb begin
        mask_wdata_s = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            mask_wdata_s[i] = (i < 32) ? cmd_bus_data[i % 32] : 1'b0;
        end
    end

    // Next-state logic for configuration, period counter, sticky flags and sweep FSM.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        ch_d     = ch_q;
        wait_d   = wait_q;
        sample_d = sample_q;

        mask_d   = wr_mask_s   ? mask_wdata_s    : mask_q;
        period_d = wr_period_s ? cmd_bus_data    : period_q;
        run_d    = wr_ctrl_s   ? cmd_bus_data[0] : run_q;

        if (wr_period_s || !run_q || (period_q == 32'd0) || tick_s) begin
            cnt_d = 32'd0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        // Clear has priority over a same-cycle set.
        ovf_d = clr_s ? 1'b0 : (ovf_q | ((state_q == S_PUSH) & fifo_full));
        ovr_d = clr_s ? 1'b0 : (ovr_q | (tick_s & (state_q != S_IDLE)));

        case (state_q)
            S_IDLE: begin
                if (tick_s && (mask_q != '0)) begin
                    sweep_d = mask_q;
                    ch_d    = lowest_set(mask_q);
                    state_d = S_SELECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SELECT: begin
                sweep_d = clear_bit(sweep_q, ch_q);
                wait_d  = WAIT_LOAD;
                state_d = (DATA_LATENCY > 1) ? S_WAIT : S_CAPTURE;
            end
            S_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    wait_d  = wait_q - 4'd1;
                    state_d = S_WAIT;
                end
            end
            S_CAPTURE: begin
                sample_d = sample_data[15:0];
                state_d  = S_PUSH;
            end
            S_PUSH: begin
                if (run_q && (sweep_q != '0)) begin
                    ch_d    = lowest_set(sweep_q);
                    state_d = S_SELECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            sweep_q  <= '0;
            period_q <= 32'd0;
            cnt_q    <= 32'd0;
            run_q    <= 1'b0;
            ovf_q    <= 1'b0;
            ovr_q    <= 1'b0;
            ch_q     <= 8'd0;
            wait_q   <= 4'd0;
            sample_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            sweep_q  <= sweep_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            ovf_q    <= ovf_d;
            ovr_q    <= ovr_d;
            ch_q     <= ch_d;
            wait_q   <= wait_d;
            sample_q <= sample_d;
        end
    end

    // The push strobe follows fifo_full in the push cycle itself, so it cannot be pre-registered.
    assign busy           = (state_q != S_IDLE);
    assign channel_select = busy ? ch_q : 8'd0;
    assign output_sample  = (state_q == S_SELECT);
    assign fifo_wr_en     = (state_q == S_PUSH) & ~fifo_full;
    assign fifo_din       = fifo_wr_en ? {ch_q, sample_q} : 24'd0;
    assign overflow       = ovf_q;
    assign overrun        = ovr_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Randomized self-checking bench for sample_sequencer with a sweep-schedule reference model.
module tb_sample_sequencer;

    localparam logic [18:0] BASE    = 19'h00F0;
    localparam int          NCH     = 16;
    localparam int          DL      = 2;
    localparam int          CH_COST = DL + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_bus_en, cmd_bus_wr;
    logic [18:0] cmd_bus_addr;
    logic [31:0] cmd_bus_data;
    logic [7:0]  channel_select;
    logic        output_sample;
    logic [31:0] sample_data;
    logic [23:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        busy, overflow, overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int full_mode = 0;

    sample_sequencer #(.BASE_ADDR(BASE), .NUM_CHANNELS(NCH), .DATA_LATENCY(DL)) dut (
        .clk(clk), .rst(rst),
        .cmd_bus_en(cmd_bus_en), .cmd_bus_wr(cmd_bus_wr),
        .cmd_bus_addr(cmd_bus_addr), .cmd_bus_data(cmd_bus_data),
        .channel_select(channel_select), .output_sample(output_sample),
        .sample_data(sample_data),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .busy(busy), .overflow(overflow), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sweep is a list of channels; position within the sweep gives the phase.
    logic [15:0] m_mask;
    logic [31:0] m_period, m_cnt;
    logic        m_run, m_ovf, m_ovr, m_active;
    int          m_pos, m_n;
    int          m_list[NCH];
    logic [15:0] m_sample;
    int          k, off;
    logic        tick, e_push, e_strobe, e_wr, e_busy, wr, nxt_ovf, nxt_ovr;
    logic [7:0]  e_ch, e_sel;
    logic [23:0] e_din;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_sel", channel_select, 0);
            check("rst_strobe", output_sample, 0);
            check("rst_wr", fifo_wr_en, 0);
            check("rst_din", fifo_din, 0);
            check("rst_busy", busy, 0);
            check("rst_ovf", overflow, 0);
            check("rst_ovr", overrun, 0);
            m_mask = 16'd0; m_period = 32'd0; m_cnt = 32'd0; m_run = 1'b0;
            m_ovf = 1'b0; m_ovr = 1'b0; m_active = 1'b0; m_pos = 0; m_n = 0;
        end else begin
            e_busy = 1'b0; e_sel = 8'd0; e_strobe = 1'b0; e_push = 1'b0; e_ch = 8'd0;
            k = 0; off = 0;
            if (m_active) begin
                k = m_pos / CH_COST;
                off = m_pos % CH_COST;
                e_ch = 8'(m_list[k]);
                e_busy = 1'b1;
                e_sel = e_ch;
                e_strobe = (off == 0);
                e_push = (off == DL + 1);
            end
            e_wr = e_push && !fifo_full;
            e_din = e_wr ? {e_ch, m_sample} : 24'd0;
            check("channel_select", channel_select, e_sel);
            check("output_sample", output_sample, e_strobe);
            check("fifo_wr_en", fifo_wr_en, e_wr);
            check("fifo_din", fifo_din, e_din);
            check("busy", busy, e_busy);
            check("overflow", overflow, m_ovf);
            check("overrun", overrun, m_ovr);

            tick = m_run && (m_period != 32'd0) && (m_cnt == m_period - 32'd1);
            wr = cmd_bus_en && cmd_bus_wr;
            nxt_ovf = m_ovf | (e_push && fifo_full);
            nxt_ovr = m_ovr | (tick && m_active);
            if (m_active) begin
                if (off == DL) m_sample = sample_data[15:0];
                if (e_push) begin
                    if (!m_run || (k + 1 >= m_n)) m_active = 1'b0;
                    else m_pos++;
                end else begin
                    m_pos++;
                end
            end else if (tick && (m_mask != 16'd0)) begin
                m_n = 0;
                for (int i = 0; i < NCH; i++) begin
                    if (m_mask[i]) begin
                        m_list[m_n] = i;
                        m_n++;
                    end
                end
                m_active = 1'b1;
                m_pos = 0;
            end
            if ((wr && cmd_bus_addr == BASE + 19'd1) || !m_run || m_period == 32'd0 || tick)
                m_cnt = 32'd0;
            else
                m_cnt = m_cnt + 32'd1;
            if (wr && cmd_bus_addr == BASE) m_mask = cmd_bus_data[15:0];
            if (wr && cmd_bus_addr == BASE + 19'd1) m_period = cmd_bus_data;
            if (wr && cmd_bus_addr == BASE + 19'd2) begin
                m_run = cmd_bus_data[0];
                if (cmd_bus_data[1]) begin
                    nxt_ovf = 1'b0;
                    nxt_ovr = 1'b0;
                end
            end
            m_ovf = nxt_ovf;
            m_ovr = nxt_ovr;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        sample_data = $urandom;
        if (full_mode == 1) fifo_full = ($urandom_range(0, 3) == 0);
    endtask

    task automatic wr_reg(input logic [18:0] a, input logic [31:0] d);
        cmd_bus_en = 1'b1; cmd_bus_wr = 1'b1; cmd_bus_addr = a; cmd_bus_data = d;
        cyc();
        cmd_bus_en = 1'b0; cmd_bus_wr = 1'b0;
        cmd_bus_addr = 19'($urandom); cmd_bus_data = $urandom;
    endtask

    task automatic wait_strobe(input logic [7:0] ch, input int max, output int waited);
        waited = 0;
        while (!(output_sample && channel_select == ch) && waited < max) begin
            cyc();
            waited++;
        end
        n_checks++;
        if (waited >= max) begin
            n_fail++;
            $display("FAIL wait_strobe ch%0d: no strobe within %0d cycles", ch, max);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, cnt, strobes, pushes, busies;
        logic [31:0] d;
        rst = 1'b1; cmd_bus_en = 1'b0; cmd_bus_wr = 1'b0; cmd_bus_addr = 19'd0;
        cmd_bus_data = 32'd0; sample_data = 32'd0; fifo_full = 1'b0;
        cyc();
        check("reset_busy", busy, 0);
        check("reset_fifo_wr_en", fifo_wr_en, 0);
        check("reset_output_sample", output_sample, 0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Mask 0x0005, period 100: two pushes per period in ascending order.
        wr_reg(BASE, 32'h5);
        wr_reg(BASE + 19'd1, 32'd100);
        wr_reg(BASE + 19'd2, 32'h1);
        wait_strobe(8'd0, 200, w);
        check("first_strobe_delay", w, 100);
        cyc(); cyc(); cyc();
        check("ch0_push_wr", fifo_wr_en, 1);
        check("ch0_push_ch", fifo_din[23:16], 8'h00);
        cyc();
        check("ch2_strobe", output_sample, 1);
        check("ch2_select", channel_select, 8'd2);
        cyc(); cyc(); cyc();
        check("ch2_push_wr", fifo_wr_en, 1);
        check("ch2_push_ch", fifo_din[23:16], 8'h02);
        cyc();
        check("sweep_done_busy", busy, 0);
        wait_strobe(8'd0, 200, w);
        check("second_sweep_delay", w, 92);

        // fifo_full during the ch2 push drops that sample and sets overflow.
        wait_strobe(8'd2, 10, w);
        fifo_full = 1'b1;
        cyc(); cyc(); cyc();
        check("full_push_wr", fifo_wr_en, 0);
        cyc();
        fifo_full = 1'b0;
        check("overflow_set", overflow, 1);
        for (int i = 0; i < 10; i++) cyc();
        check("overflow_sticky", overflow, 1);
        wr_reg(BASE + 19'd2, 32'h3);
        check("overflow_cleared", overflow, 0);
        wr_reg(BASE + 19'd2, 32'h0);
        for (int i = 0; i < 10; i++) cyc();

        // Full mask with a short period: 64-cycle sweep and overrun.
        wr_reg(BASE, 32'hFFFF);
        wr_reg(BASE + 19'd1, 32'd20);
        wr_reg(BASE + 19'd2, 32'h1);
        wait_strobe(8'd0, 50, w);
        cnt = 0;
        while (busy && cnt < 200) begin
            cyc();
            cnt++;
        end
        check("full_sweep_len", cnt, 64);
        check("overrun_set", overrun, 1);
        wr_reg(BASE + 19'd2, 32'h2);
        cnt = 0;
        while (busy && cnt < 200) begin
            cyc();
            cnt++;
        end
        check("stop_idle", busy, 0);

        // Run cleared during ch3's wait: ch3 still pushes, then the sweep ends.
        wr_reg(BASE, 32'hFF);
        wr_reg(BASE + 19'd1, 32'd30);
        wr_reg(BASE + 19'd2, 32'h1);
        wait_strobe(8'd3, 100, w);
        cyc();
        wr_reg(BASE + 19'd2, 32'h0);
        cyc();
        check("stop_push_wr", fifo_wr_en, 1);
        check("stop_push_ch", fifo_din[23:16], 8'h03);
        cyc();
        check("stop_busy", busy, 0);
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (output_sample) strobes++;
        end
        check("stop_no_strobes", strobes, 0);

        // Asynchronous reset in the middle of a strobe.
        wr_reg(BASE, 32'hF);
        wr_reg(BASE + 19'd1, 32'd10);
        wr_reg(BASE + 19'd2, 32'h1);
        wait_strobe(8'd0, 50, w);
        #2 rst = 1'b1;
        #1;
        check("arst_strobe", output_sample, 0);
        check("arst_busy", busy, 0);
        check("arst_wr", fifo_wr_en, 0);
        check("arst_sel", channel_select, 0);
        cyc();
        rst = 1'b0;
        pushes = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (fifo_wr_en) pushes++;
        end
        check("arst_no_push", pushes, 0);

        // Empty mask with run set: nothing happens; BASE+3 is outside the window.
        wr_reg(BASE + 19'd1, 32'd5);
        wr_reg(BASE + 19'd2, 32'h1);
        wr_reg(BASE + 19'd3, 32'hFFFF_FFFF);
        strobes = 0; pushes = 0; busies = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (output_sample) strobes++;
            if (fifo_wr_en) pushes++;
            if (busy) busies++;
        end
        check("empty_strobes", strobes, 0);
        check("empty_pushes", pushes, 0);
        check("empty_busy", busies, 0);

        // Random configuration traffic with random backpressure.
        full_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 5))
                    0: wr_reg(BASE, ($urandom_range(0, 1) == 0) ? ($urandom & $urandom) : $urandom);
                    1: wr_reg(BASE + 19'd1, 32'($urandom_range(0, 40)));
                    2: begin
                        d = 32'd0;
                        d[0] = ($urandom_range(0, 3) != 0);
                        d[1] = ($urandom_range(0, 3) == 0);
                        wr_reg(BASE + 19'd2, d);
                    end
                    3: wr_reg(BASE + 19'd3, $urandom);
                    4: wr_reg(19'($urandom), $urandom);
                    default: begin
                        cmd_bus_en = 1'b1; cmd_bus_wr = 1'b0;
                        cmd_bus_addr = BASE + 19'd1; cmd_bus_data = $urandom;
                        cyc();
                        cmd_bus_en = 1'b0;
                    end
                endcase
            end else begin
                cyc();
            end
        end
        full_mode = 0;
        fifo_full = 1'b0;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
